// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame parameters, receiver state encoding
// and parity helper, for use by uart_rx and a future uart_tx.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_DATA_BITS    = 8;
  localparam bit          UART_PARITY_EN    = 1'b0;
  localparam bit          UART_PARITY_ODD   = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Zero-extended data leaves the XOR unchanged, so any width up to 32 fits.
  function automatic logic parity_calc(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with a configurable reset value.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver (8N1 by default) with a valid/ready output
// register and single-cycle error pulses; bad frames are discarded.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter bit          PARITY_EN    = UART_PARITY_EN,
  parameter bit          PARITY_ODD   = UART_PARITY_ODD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 sync_in;
  logic                 fin_ok;
  logic                 fin_ferr;
  logic                 fin_perr;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (sync_in)
  );

  assign busy = (state != IDLE);

  // Frame outcome is registered at the stop sample and acted on one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      fin_ok   <= 1'b0;
      fin_ferr <= 1'b0;
      fin_perr <= 1'b0;
    end else begin
      fin_ok   <= 1'b0;
      fin_ferr <= 1'b0;
      fin_perr <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!sync_in) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            perr  <= 1'b0;
            state <= sync_in ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= sync_in;
            if (idx == LAST_IDX) state <= PARITY_EN ? PARITY : STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (sync_in != parity_calc(32'(shreg), PARITY_ODD)) perr <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (!sync_in) begin
              fin_ferr <= 1'b1;
              state    <= BREAK;
            end else begin
              fin_perr <= perr;
              fin_ok   <= !perr;
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (sync_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= fin_ferr;
      parity_err  <= fin_perr;
      overrun     <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (fin_ok) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_a = 1'b1;
  logic       in_p = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] dout_a, dout_p;
  logic       dv_a, busy_a, ferr_a, perr_a, ovr_a;
  logic       dv_p, busy_p, ferr_p, perr_p, ovr_p;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e_cyc = 0;

  int         n_valid_a = 0, n_ferr_a = 0, n_perr_a = 0, n_ovr_a = 0;
  int         rise_cyc_a = -1, ferr_cyc_a = -1;
  logic [7:0] rise_word_a = '0;
  logic       dvq_a = 1'b0;
  int         n_valid_p = 0, n_ferr_p = 0, n_perr_p = 0, n_ovr_p = 0;
  logic [7:0] rise_word_p = '0;
  logic       dvq_p = 1'b0;

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_a (
    .clk(clk), .reset(reset), .in(in_a), .data_out(dout_a), .data_valid(dv_a),
    .data_ready(data_ready), .busy(busy_a), .framing_err(ferr_a),
    .parity_err(perr_a), .overrun(ovr_a)
  );

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_p (
    .clk(clk), .reset(reset), .in(in_p), .data_out(dout_p), .data_valid(dv_p),
    .data_ready(data_ready), .busy(busy_p), .framing_err(ferr_p),
    .parity_err(perr_p), .overrun(ovr_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the inactive edge; the main sequence reads deltas.
  always @(negedge clk) begin
    if (dv_a && !dvq_a) begin
      rise_cyc_a  = cyc;
      rise_word_a = dout_a;
    end
    dvq_a = dv_a;
    if (dv_a)   n_valid_a++;
    if (ferr_a) begin n_ferr_a++; ferr_cyc_a = cyc; end
    if (perr_a) n_perr_a++;
    if (ovr_a)  n_ovr_a++;
    if (dv_p && !dvq_p) rise_word_p = dout_p;
    dvq_p = dv_p;
    if (dv_p)   n_valid_p++;
    if (ferr_p) n_ferr_p++;
    if (perr_p) n_perr_p++;
    if (ovr_p)  n_ovr_p++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_wait();
    repeat (16) tick();
  endtask

  task automatic drive(input logic sel, input logic v);
    if (sel) in_p = v;
    else     in_a = v;
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    drive(sel, 1'b0);
    e_cyc = cyc + 1;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      bit_wait();
    end
    if (par_en) begin
      drive(sel, par_bit);
      bit_wait();
    end
    drive(sel, stop_bit);
    bit_wait();
  endtask

  int  v0, f0, p0, o0;
  bit  seen;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_data_out", 32'(dout_a), 32'h0);
    check("rst_valid", 32'(dv_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_errs", 32'({ferr_a, perr_a, ovr_a}), 32'h0);
    check("rst_p_busy", 32'(busy_p), 32'h0);
    reset = 1'b0;
    repeat (10) tick();

    // 1: 0xA5, exact latency
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a; o0 = n_ovr_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("t1_valid_cycle", 32'(rise_cyc_a), 32'(e_cyc + 155));
    check("t1_word", 32'(rise_word_a), 32'hA5);
    check("t1_valid_len", 32'(n_valid_a - v0), 32'd1);
    check("t1_no_errs", 32'((n_ferr_a - f0) + (n_perr_a - p0) + (n_ovr_a - o0)), 32'd0);
    check("t1_busy_after", 32'(busy_a), 32'h0);

    // 2: start-bit glitch
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a;
    seen = 1'b0;
    in_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) in_a = 1'b1;
      tick();
      if (busy_a) seen = 1'b1;
    end
    check("t2_busy_seen", 32'(seen), 32'h1);
    check("t2_busy_low", 32'(busy_a), 32'h0);
    check("t2_no_valid_errs", 32'((n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0)), 32'd0);
    repeat (10) tick();

    // 3: framing error with held break, then recovery
    v0 = n_valid_a; f0 = n_ferr_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (48) tick();
    in_a = 1'b1;
    repeat (20) tick();
    check("t3_ferr_count", 32'(n_ferr_a - f0), 32'd1);
    check("t3_ferr_cycle", 32'(ferr_cyc_a), 32'(e_cyc + 155));
    check("t3_no_valid", 32'(n_valid_a - v0), 32'd0);
    v0 = n_valid_a;
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("t3_next_word", 32'(rise_word_a), 32'h7E);
    check("t3_next_valid", 32'(n_valid_a - v0), 32'd1);

    // 4: overrun
    data_ready = 1'b0;
    o0 = n_ovr_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    check("t4_valid_held", 32'(dv_a), 32'h1);
    check("t4_word_kept", 32'(dout_a), 32'h11);
    check("t4_overrun_once", 32'(n_ovr_a - o0), 32'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t4_valid_cleared", 32'(dv_a), 32'h0);
    data_ready = 1'b1;
    repeat (5) tick();

    // 5: even parity
    v0 = n_valid_p; p0 = n_perr_p;
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    check("t5_perr_pulse", 32'(n_perr_p - p0), 32'd1);
    check("t5_bad_no_valid", 32'(n_valid_p - v0), 32'd0);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    check("t5_good_word", 32'(rise_word_p), 32'h03);
    check("t5_good_valid", 32'(n_valid_p - v0), 32'd1);
    check("t5_p_no_other_errs", 32'(n_ferr_p + n_ovr_p), 32'd0);

    // 6: reset during data bits of 0xFF
    f0 = n_ferr_a; p0 = n_perr_a; o0 = n_ovr_a; v0 = n_valid_a;
    in_a = 1'b0;
    bit_wait();
    in_a = 1'b1;
    repeat (40) tick();
    check("t6_busy_before", 32'(busy_a), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy_after", 32'(busy_a), 32'h0);
    check("t6_valid_after", 32'(dv_a), 32'h0);
    repeat (120) tick();
    check("t6_no_pulses", 32'((n_ferr_a - f0) + (n_perr_a - p0) + (n_ovr_a - o0) + (n_valid_a - v0)), 32'd0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("t6_next_word", 32'(rise_word_a), 32'h5A);
    check("t6_next_valid", 32'(n_valid_a - v0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
